anc_lms_engine: RTL and testbench

//  Parametrised, time-multiplexed FxLMS-style ANC core: one MAC serves filtering and adaptation.

---
 rtl/anc_lms_engine.sv | 260 ++++++++++++++++++++++++++
 tb/tb_anc_lms_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anc_lms_engine.sv
// anc_lms_engine
//   Time-multiplexed FxLMS-style active noise control core. A single
//   multiplier/adder path serves both the FIR filter pass and the LMS
//   coefficient adaptation pass, sequenced by one FSM per sample.
//
// Ports
//   Clk_100M     in   system clock, rising edge
//   ResetN       in   asynchronous reset, active low
//   SampleValid  in   one-cycle strobe qualifying RefIn/MicIn/Mode
//   RefIn        in   reference noise sample x(n), signed DATA_W
//   MicIn        in   error microphone sample, signed DATA_W
//   Mode         in   00 adapt, 01 freeze, 10 bypass, 11 clear
//   Busy         out  high from the cycle after accept through the OutValid cycle
//   OutValid     out  one-cycle strobe qualifying AntiNoise/ErrOut/SatFlag
//   AntiNoise    out  saturated filter output y(n)
//   ErrOut       out  saturated error e(n)
//   SatFlag      out  y or e was clamped for this sample
//   Overrun      out  one-cycle pulse: a sample arrived while Busy and was dropped
module anc_lms_engine #(
  parameter int DATA_W   = 11,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 16,
  parameter int MU_SHIFT = 8,
  parameter int ACC_W    = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                     Clk_100M,
  input  logic                     ResetN,
  input  logic                     SampleValid,
  input  logic signed [DATA_W-1:0] RefIn,
  input  logic signed [DATA_W-1:0] MicIn,
  input  logic [1:0]               Mode,
  output logic                     Busy,
  output logic                     OutValid,
  output logic signed [DATA_W-1:0] AntiNoise,
  output logic signed [DATA_W-1:0] ErrOut,
  output logic                     SatFlag,
  output logic                     Overrun
);

  localparam int IDX_W   = $clog2(TAPS);
  localparam int PROD_W  = DATA_W + COEF_W;
  localparam int E_W     = DATA_W + 1;
  localparam int EPROD_W = 2 * DATA_W;
  localparam int UPD_W   = ((COEF_W > EPROD_W) ? COEF_W : EPROD_W) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [COEF_W-1:0] COEF_MAX = {1'b0, {(COEF_W-1){1'b1}}};
  localparam logic signed [COEF_W-1:0] COEF_MIN = {1'b1, {(COEF_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_MAC,
    S_ERR,
    S_UPDATE,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_ADAPT  = 2'b00,
    MODE_FREEZE = 2'b01,
    MODE_BYPASS = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  state_e                     state_q;
  mode_e                      mode_q;
  logic [IDX_W-1:0]           tapIdx_q;
  logic signed [DATA_W-1:0]   refLat_q;
  logic signed [DATA_W-1:0]   micLat_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [DATA_W-1:0]   y_q;
  logic signed [DATA_W-1:0]   e_q;
  logic                       sat_q;
  logic signed [DATA_W-1:0]   x_q [TAPS];
  logic signed [COEF_W-1:0]   w_q [TAPS];
  logic                       busy_q;
  logic                       outValid_q;
  logic signed [DATA_W-1:0]   antiNoise_q;
  logic signed [DATA_W-1:0]   errOut_q;
  logic                       satFlag_q;
  logic                       overrun_q;

  logic signed [PROD_W-1:0]   macProd;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    accShift;
  logic signed [DATA_W-1:0]   y_d;
  logic signed [E_W-1:0]      eWide;
  logic signed [DATA_W-1:0]   e_d;
  logic                       sat_d;
  logic signed [EPROD_W-1:0]  errProd;
  logic signed [EPROD_W-1:0]  errStep;
  logic signed [UPD_W-1:0]    wSum;
  logic signed [COEF_W-1:0]   w_d;

  // Shared datapath: the MAC term w[k]*x[k] during filtering, and the
  // coefficient step e*x[k] during adaptation, both indexed by tapIdx_q.
  // Operands are sign-extended to the product width so the multiply is
  // exact before accumulation or shifting.
  always_comb begin
    macProd  = PROD_W'(w_q[tapIdx_q]) * PROD_W'(x_q[tapIdx_q]);
    acc_d    = acc_q + ACC_W'(macProd);

    // The accumulator holds y in Q(COEF_W-1); drop the fraction, then clamp.
    accShift = acc_q >>> (COEF_W - 1);
    y_d      = accShift[DATA_W-1:0];
    sat_d    = 1'b0;
    if (accShift > ACC_W'(DATA_MAX)) begin
      y_d   = DATA_MAX;
      sat_d = 1'b1;
    end else if (accShift < ACC_W'(DATA_MIN)) begin
      y_d   = DATA_MIN;
      sat_d = 1'b1;
    end

    // Error uses the already-clamped y, one bit wider so the subtraction
    // cannot wrap before the clamp.
    eWide = E_W'(micLat_q) - E_W'(y_d);
    e_d   = eWide[DATA_W-1:0];
    if (eWide > E_W'(DATA_MAX)) begin
      e_d   = DATA_MAX;
      sat_d = 1'b1;
    end else if (eWide < E_W'(DATA_MIN)) begin
      e_d   = DATA_MIN;
      sat_d = 1'b1;
    end

    errProd = EPROD_W'(e_q) * EPROD_W'(x_q[tapIdx_q]);
    errStep = errProd >>> MU_SHIFT;
    wSum    = UPD_W'(w_q[tapIdx_q]) + UPD_W'(errStep);
    w_d     = wSum[COEF_W-1:0];
    if (wSum > UPD_W'(COEF_MAX)) begin
      w_d = COEF_MAX;
    end else if (wSum < UPD_W'(COEF_MIN)) begin
      w_d = COEF_MIN;
    end
  end

  // Sample sequencer: IDLE -> SHIFT -> MAC -> ERR -> UPDATE -> DONE.
  // Freeze skips UPDATE, bypass skips MAC and UPDATE. Results are published
  // to the output registers on the edge entering DONE so they are valid
  // exactly in the OutValid cycle and then hold until the next sample.
  always_ff @(posedge Clk_100M or negedge ResetN) begin
    if (!ResetN) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_ADAPT;
      tapIdx_q    <= '0;
      refLat_q    <= '0;
      micLat_q    <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      e_q         <= '0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
      outValid_q  <= 1'b0;
      antiNoise_q <= '0;
      errOut_q    <= '0;
      satFlag_q   <= 1'b0;
      overrun_q   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        w_q[k] <= '0;
      end
    end else begin
      outValid_q <= 1'b0;
      // Any strobe outside IDLE (including the DONE cycle) is dropped.
      overrun_q  <= SampleValid && (state_q != S_IDLE);

      case (state_q)
        S_IDLE: begin
          if (SampleValid) begin
            refLat_q <= RefIn;
            micLat_q <= MicIn;
            mode_q   <= mode_e'(Mode);
            busy_q   <= 1'b1;
            state_q  <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          for (int k = TAPS - 1; k > 0; k--) begin
            x_q[k] <= x_q[k-1];
          end
          x_q[0]   <= refLat_q;
          acc_q    <= '0;
          tapIdx_q <= '0;
          state_q  <= (mode_q == MODE_BYPASS) ? S_ERR : S_MAC;
        end

        S_MAC: begin
          acc_q <= acc_d;
          if (tapIdx_q == LAST_IDX) begin
            tapIdx_q <= '0;
            state_q  <= S_ERR;
          end else begin
            tapIdx_q <= tapIdx_q + IDX_W'(1);
          end
        end

        S_ERR: begin
          y_q      <= y_d;
          e_q      <= e_d;
          sat_q    <= sat_d;
          tapIdx_q <= '0;
          if (mode_q == MODE_ADAPT || mode_q == MODE_CLEAR) begin
            state_q <= S_UPDATE;
          end else begin
            antiNoise_q <= y_d;
            errOut_q    <= e_d;
            satFlag_q   <= sat_d;
            outValid_q  <= 1'b1;
            state_q     <= S_DONE;
          end
        end

        S_UPDATE: begin
          // Clear wipes both coefficients and history; y/e were already
          // captured in ERR so the outputs reflect the pre-clear filter.
          if (mode_q == MODE_CLEAR) begin
            w_q[tapIdx_q] <= '0;
            x_q[tapIdx_q] <= '0;
          end else begin
            w_q[tapIdx_q] <= w_d;
          end
          if (tapIdx_q == LAST_IDX) begin
            tapIdx_q    <= '0;
            antiNoise_q <= y_q;
            errOut_q    <= e_q;
            satFlag_q   <= sat_q;
            outValid_q  <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            tapIdx_q <= tapIdx_q + IDX_W'(1);
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign OutValid  = outValid_q;
  assign AntiNoise = antiNoise_q;
  assign ErrOut    = errOut_q;
  assign SatFlag   = satFlag_q;
  assign Overrun   = overrun_q;

endmodule

// File: tb/tb_anc_lms_engine.sv
// tb_anc_lms_engine
//   Self-checking bench for anc_lms_engine. A sample-level reference model
//   (delay line and coefficient arrays updated with plain integer maths)
//   predicts y, e, saturation and latency for each accepted sample; directed
//   steps cover reset, latency per mode, adaptation, saturation, overrun and
//   clear, followed by a randomized run.
module tb_anc_lms_engine;

  localparam int DATA_W   = 11;
  localparam int COEF_W   = 16;
  localparam int TAPS     = 16;
  localparam int MU_SHIFT = 4;

  logic                     Clk_100M;
  logic                     ResetN;
  logic                     SampleValid;
  logic signed [DATA_W-1:0] RefIn;
  logic signed [DATA_W-1:0] MicIn;
  logic [1:0]               Mode;
  logic                     Busy;
  logic                     OutValid;
  logic signed [DATA_W-1:0] AntiNoise;
  logic signed [DATA_W-1:0] ErrOut;
  logic                     SatFlag;
  logic                     Overrun;

  int checks = 0;
  int errors = 0;

  longint mx [TAPS];
  longint mw [TAPS];

  anc_lms_engine #(
    .DATA_W  (DATA_W),
    .COEF_W  (COEF_W),
    .TAPS    (TAPS),
    .MU_SHIFT(MU_SHIFT)
  ) dut (
    .Clk_100M   (Clk_100M),
    .ResetN     (ResetN),
    .SampleValid(SampleValid),
    .RefIn      (RefIn),
    .MicIn      (MicIn),
    .Mode       (Mode),
    .Busy       (Busy),
    .OutValid   (OutValid),
    .AntiNoise  (AntiNoise),
    .ErrOut     (ErrOut),
    .SatFlag    (SatFlag),
    .Overrun    (Overrun)
  );

  // 100 MHz clock.
  initial Clk_100M = 1'b0;
  always #5 Clk_100M = ~Clk_100M;

  // Hard stop in case the sequence itself wedges.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts, asserts and reports.
  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint clampTo(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Division by 2^s rounded toward minus infinity.
  function automatic longint floorPow2(input longint v, input int s);
    longint d;
    longint r;
    d = longint'(1) <<< s;
    r = ((v % d) + d) % d;
    return (v - r) / d;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < TAPS; k++) begin
      mx[k] = 0;
      mw[k] = 0;
    end
  endtask

  // One full sample of the algorithm at integer level.
  task automatic modelSample(input int r, input int m, input int md,
                             output int y, output int e, output int s);
    longint acc;
    longint yRaw;
    longint eRaw;
    longint yc;
    longint ec;
    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = r;
    acc = 0;
    if (md != 2) begin
      for (int k = 0; k < TAPS; k++) acc += mw[k] * mx[k];
    end
    yRaw = floorPow2(acc, COEF_W - 1);
    yc   = clampTo(yRaw, DATA_W);
    eRaw = m - yc;
    ec   = clampTo(eRaw, DATA_W);
    if (md == 0) begin
      for (int k = 0; k < TAPS; k++)
        mw[k] = clampTo(mw[k] + floorPow2(ec * mx[k], MU_SHIFT), COEF_W);
    end else if (md == 3) begin
      for (int k = 0; k < TAPS; k++) begin
        mw[k] = 0;
        mx[k] = 0;
      end
    end
    y = int'(yc);
    e = int'(ec);
    s = ((yc != yRaw) || (ec != eRaw)) ? 1 : 0;
  endtask

  // Presents one sample in the current cycle (call at a falling edge), follows
  // it to OutValid and one cycle beyond. intruderAt > 0 injects a junk strobe
  // that many cycles after the accept; inputs carry junk while busy.
  task automatic applyStimulus(input int r, input int m, input int md,
                               input int intruderAt);
    int  y;
    int  e;
    int  s;
    int  lat;
    int  n;
    bit  done;
    modelSample(r, m, md, y, e, s);
    lat = (md == 2) ? 3 : (md == 1) ? (TAPS + 3) : (2 * TAPS + 3);
    SampleValid = 1'b1;
    RefIn       = DATA_W'(r);
    MicIn       = DATA_W'(m);
    Mode        = 2'(md);
    n    = 0;
    done = 1'b0;
    while (!done && n < 4 * TAPS + 20) begin
      @(negedge Clk_100M);
      n++;
      checkOutput("busy_high", Busy, 1);
      checkOutput("overrun_in", Overrun, (intruderAt > 0 && n == intruderAt + 1) ? 1 : 0);
      if (OutValid === 1'b1) done = 1'b1;
      SampleValid = (n == intruderAt);
      RefIn       = DATA_W'($urandom);
      MicIn       = DATA_W'($urandom);
      Mode        = 2'($urandom);
    end
    checkOutput("latency", n, lat);
    checkOutput("anti_noise", AntiNoise, y);
    checkOutput("err_out", ErrOut, e);
    checkOutput("sat_flag", SatFlag, s);
    @(negedge Clk_100M);
    checkOutput("busy_drop", Busy, 0);
    checkOutput("outvalid_single", OutValid, 0);
    checkOutput("overrun_post", Overrun, (intruderAt == lat) ? 1 : 0);
    SampleValid = 1'b0;
  endtask

  task automatic pulseReset();
    ResetN = 1'b0;
    @(negedge Clk_100M);
    ResetN = 1'b1;
    modelReset();
    @(negedge Clk_100M);
  endtask

  function automatic int randSample();
    return int'($urandom_range(0, 2047)) - 1024;
  endfunction

  initial begin
    int r;
    int m;
    int md;
    int lat;
    int intr;

    ResetN      = 1'b0;
    SampleValid = 1'b0;
    RefIn       = '0;
    MicIn       = '0;
    Mode        = 2'b00;
    modelReset();
    repeat (3) @(negedge Clk_100M);
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_outvalid", OutValid, 0);
    checkOutput("rst_anti", AntiNoise, 0);
    checkOutput("rst_err", ErrOut, 0);
    checkOutput("rst_sat", SatFlag, 0);
    checkOutput("rst_overrun", Overrun, 0);
    ResetN = 1'b1;
    @(negedge Clk_100M);

    // Latency per mode plus a few adaptation steps to build state.
    $display("[TB] latency and mode steps");
    applyStimulus(300, -200, 0, 0);
    applyStimulus(-400, 350, 0, 0);
    applyStimulus(512, 100, 1, 0);
    m = randSample();
    applyStimulus(randSample(), m, 2, 0);
    checkOutput("bypass_err_eq_mic", ErrOut, m);
    checkOutput("bypass_anti_zero", AntiNoise, 0);
    applyStimulus(200, 900, 0, 0);

    // Reset in the middle of the MAC phase.
    $display("[TB] reset mid-operation");
    SampleValid = 1'b1;
    RefIn       = DATA_W'(777);
    MicIn       = DATA_W'(-333);
    Mode        = 2'b00;
    @(negedge Clk_100M);
    SampleValid = 1'b0;
    repeat (5) @(negedge Clk_100M);
    ResetN = 1'b0;
    #1;
    checkOutput("midrst_busy", Busy, 0);
    checkOutput("midrst_outvalid", OutValid, 0);
    checkOutput("midrst_anti", AntiNoise, 0);
    checkOutput("midrst_err", ErrOut, 0);
    checkOutput("midrst_sat", SatFlag, 0);
    @(negedge Clk_100M);
    ResetN = 1'b1;
    modelReset();
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk_100M);
      checkOutput("midrst_no_outvalid", OutValid, 0);
      checkOutput("midrst_idle", Busy, 0);
    end
    applyStimulus(100, 50, 0, 0);
    checkOutput("post_rst_anti", AntiNoise, 0);

    // Adaptation with a known step.
    $display("[TB] adaptation");
    pulseReset();
    applyStimulus(256, 64, 0, 0);
    checkOutput("adapt1_anti", AntiNoise, 0);
    checkOutput("adapt1_err", ErrOut, 64);
    applyStimulus(256, 64, 0, 0);
    checkOutput("adapt2_anti", AntiNoise, 8);
    checkOutput("adapt2_err", ErrOut, 56);

    // Saturation: one large adapt step pins w[0] at full scale.
    $display("[TB] saturation");
    pulseReset();
    applyStimulus(1023, 1023, 0, 0);
    checkOutput("satpre_flag", SatFlag, 0);
    applyStimulus(1023, -1024, 0, 0);
    checkOutput("sat_anti", AntiNoise, 1022);
    checkOutput("sat_err", ErrOut, -1024);
    checkOutput("sat_flag_set", SatFlag, 1);

    // Overrun: second strobe five cycles after accept, and one in DONE.
    $display("[TB] overrun");
    applyStimulus(randSample(), randSample(), 0, 5);
    applyStimulus(randSample(), randSample(), 1, TAPS + 3);
    applyStimulus(randSample(), randSample(), 2, 1);

    // Clear wipes history and coefficients.
    $display("[TB] clear");
    for (int i = 0; i < 10; i++) applyStimulus(randSample(), randSample(), 0, 0);
    applyStimulus(randSample(), randSample(), 3, 0);
    applyStimulus(500, randSample(), 0, 0);
    checkOutput("clear_anti_zero", AntiNoise, 0);

    // Randomized run with mixed modes, overruns and idle gaps.
    $display("[TB] random run");
    for (int i = 0; i < 40; i++) begin
      r  = int'($urandom_range(0, 9));
      md = (r < 5) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      lat = (md == 2) ? 3 : (md == 1) ? (TAPS + 3) : (2 * TAPS + 3);
      intr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat)) : 0;
      applyStimulus(randSample(), randSample(), md, intr);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge Clk_100M);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
